// File: rtl/stdp_weight_update_h1.sv
`default_nettype none
// ============================================================================
// Module   : stdp_weight_update_h1
// Brief    : Hidden-layer-1 STDP weight-update stage. Passes the spike time
//            difference to the plus-side timing lookup, adds the returned
//            delta to the stored synapse weight with saturation, and writes
//            the result back through a two-stage forwarding pipeline.
//            Optional macro STDP_UPD_STATS_EN adds update/saturation counters.
// Revision : 1.0 - initial release
// ============================================================================
module stdp_weight_update_h1 #(
  parameter int W      = 24,
  parameter int N_SYN  = 16,
  parameter int ADDR_W = 4,
  parameter int WINIT  = 1000,
  parameter int WMAX   = 8388607,
  parameter int WMIN   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [7:0]        upd_dt,
  output logic              upd_ready,
  output logic [7:0]        lut_dt,
  input  logic [W-1:0]      lut_delta,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [W-1:0]      wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [W-1:0]      rd_data
`ifdef STDP_UPD_STATS_EN
  ,
  output logic [15:0]       upd_cnt,
  output logic [15:0]       sat_cnt
`endif
);

  localparam logic signed [W:0]  c_wmax  = (W+1)'(WMAX);
  localparam logic signed [W:0]  c_wmin  = (W+1)'(WMIN);
  localparam logic [W-1:0]       c_winit = W'(WINIT);
  localparam logic [ADDR_W-1:0]  c_last  = ADDR_W'(N_SYN - 1);
  localparam logic [ADDR_W-1:0]  c_one   = ADDR_W'(1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;

  logic [W-1:0]        r_weight [N_SYN];

  logic                r_s1_valid;
  logic [ADDR_W-1:0]   r_s1_addr;
  logic                r_wr_valid;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [W-1:0]        r_wr_data;
  logic [W-1:0]        r_rd_data;

  logic                w_accept;
  logic                w_fwd;
  logic [W-1:0]        w_base;
  logic signed [W:0]   w_sum;
  logic                w_over;
  logic                w_under;
  logic [W-1:0]        w_clamped;

  // The lookup sees the raw time difference so its registered delta lines up
  // with the S1 stage one edge later.
  assign lut_dt   = upd_dt;

  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign rd_data  = r_rd_data;

  // A clr in RUN flushes S1, so an update presented on that edge is dropped.
  assign w_accept = upd_valid && upd_ready && !clr;

  // Base selection forwards the result still sitting in S2 (not yet written),
  // then computes the saturating sum one bit wider than the weight.
  assign w_fwd     = r_wr_valid && (r_wr_addr == r_s1_addr);
  assign w_base    = w_fwd ? r_wr_data : r_weight[r_s1_addr];
  assign w_sum     = $signed({w_base[W-1], w_base}) + $signed({lut_delta[W-1], lut_delta});
  assign w_over    = (w_sum > c_wmax);
  assign w_under   = (w_sum < c_wmin);
  assign w_clamped = w_over  ? c_wmax[W-1:0] :
                     w_under ? c_wmin[W-1:0] :
                               w_sum[W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and ready decode.
  always_comb begin
    w_state_nxt = r_state;
    upd_ready   = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (!clr && (r_cnt == c_last)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        upd_ready = 1'b1;
        if (clr) begin
          w_state_nxt = ST_INIT;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Init sweep counter; restarted by rst or clr.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_cnt <= (r_cnt == c_last) ? '0 : (r_cnt + c_one);
    end
  end

  // Weight storage: the sweep owns the write port during INIT, S2 otherwise.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_weight[r_cnt] <= c_winit;
    end else if (r_wr_valid) begin
      r_weight[r_wr_addr] <= r_wr_data;
    end
  end

  // Two-stage update pipeline: S1 captures the request, S2 the clamped result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_addr  <= upd_addr;
      if (clr) begin
        r_wr_valid <= 1'b0;
      end else begin
        r_wr_valid <= r_s1_valid && (lut_delta != '0);
        if (r_s1_valid) begin
          r_wr_addr <= r_s1_addr;
          r_wr_data <= w_clamped;
        end
      end
    end
  end

  // Registered read port; a same-edge write is not visible until next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_weight[rd_addr];
    end
  end

`ifdef STDP_UPD_STATS_EN
  logic        r_wr_sat;
  logic [15:0] r_upd_cnt;
  logic [15:0] r_sat_cnt;

  assign upd_cnt = r_upd_cnt;
  assign sat_cnt = r_sat_cnt;

  // Remember whether the result now in S2 had to be clamped.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wr_sat <= 1'b0;
    end else if (r_s1_valid) begin
      r_wr_sat <= w_over || w_under;
    end
  end

  // Saturating statistics counters, one count per applied update.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_upd_cnt <= '0;
      r_sat_cnt <= '0;
    end else if (r_wr_valid) begin
      if (r_upd_cnt != 16'hFFFF) begin
        r_upd_cnt <= r_upd_cnt + 16'd1;
      end
      if (r_wr_sat && (r_sat_cnt != 16'hFFFF)) begin
        r_sat_cnt <= r_sat_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stdp_weight_update_h1.sv
`default_nettype none
// ============================================================================
// Module   : tb_stdp_weight_update_h1
// Brief    : Directed self-checking bench for stdp_weight_update_h1 with a
//            registered model of the plus-side timing lookup.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stdp_weight_update_h1;

  localparam int W      = 24;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_addr;
  logic [7:0]        upd_dt;
  logic              upd_ready;
  logic [7:0]        lut_dt;
  logic [W-1:0]      lut_delta;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [W-1:0]      wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [W-1:0]      rd_data;
`ifdef STDP_UPD_STATS_EN
  logic [15:0]       upd_cnt;
  logic [15:0]       sat_cnt;
`endif

  int total = 0;
  int bad   = 0;

  stdp_weight_update_h1 dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .upd_valid (upd_valid),
    .upd_addr  (upd_addr),
    .upd_dt    (upd_dt),
    .upd_ready (upd_ready),
    .lut_dt    (lut_dt),
    .lut_delta (lut_delta),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
`ifdef STDP_UPD_STATS_EN
    ,
    .upd_cnt   (upd_cnt),
    .sat_cnt   (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Lookup model: dt 2 -> -19, dt 20 -> -181, 3..19 -> -50, otherwise 0.
  function automatic logic [W-1:0] lut_model(input logic [7:0] dt);
    if (dt == 8'd2)                   return W'(-19);
    if (dt == 8'd20)                  return W'(-181);
    if ((dt > 8'd2) && (dt < 8'd20))  return W'(-50);
    return '0;
  endfunction

  // Registered lookup, as the upstream block presents it.
  always @(posedge clk) lut_delta <= lut_model(lut_dt);

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; clr = 1'b0; upd_valid = 1'b0; upd_addr = '0; upd_dt = '0; rd_addr = '0;
    cyc(); cyc();
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL reset_upd_ready got=%0b want=0", upd_ready); end
    total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL reset_wr_valid got=%0b want=0", wr_valid); end
    total++; if (wr_addr !== 4'd0) begin bad++; $display("FAIL reset_wr_addr got=%0d want=0", wr_addr); end
    total++; if (wr_data !== 24'd0) begin bad++; $display("FAIL reset_wr_data got=%0d want=0", wr_data); end
    total++; if (rd_data !== 24'd0) begin bad++; $display("FAIL reset_rd_data got=%0d want=0", rd_data); end
`ifdef STDP_UPD_STATS_EN
    total++; if (upd_cnt !== 16'd0) begin bad++; $display("FAIL reset_upd_cnt got=%0d want=0", upd_cnt); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_init_sweep;
    int n;
    n = 0;
    while ((upd_ready !== 1'b1) && (n < 40)) begin cyc(); n++; end
    total++; if (n != 16) begin bad++; $display("FAIL init_ready_cycles got=%0d want=16", n); end
    for (int a = 0; a < 16; a++) begin
      rd_addr = ADDR_W'(a);
      cyc();
      total++; if (rd_data !== 24'd1000) begin bad++; $display("FAIL init_rd[%0d] got=%0d want=1000", a, rd_data); end
    end
  endtask

  task automatic test_single;
    upd_valid = 1'b1; upd_addr = 4'd3; upd_dt = 8'd2; rd_addr = 4'd3;
    cyc();                       // edge k
    upd_valid = 1'b0; upd_dt = 8'd0;
    total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL single_early_wr_valid got=%0b want=0", wr_valid); end
    cyc();                       // edge k+1
    total++; if (wr_valid !== 1'b1) begin bad++; $display("FAIL single_wr_valid got=%0b want=1", wr_valid); end
    total++; if (wr_addr !== 4'd3) begin bad++; $display("FAIL single_wr_addr got=%0d want=3", wr_addr); end
    total++; if (wr_data !== 24'd981) begin bad++; $display("FAIL single_wr_data got=%0d want=981", wr_data); end
    cyc();                       // edge k+2: write happens, read sees old value
    total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL single_wr_pulse got=%0b want=0", wr_valid); end
    total++; if (rd_data !== 24'd1000) begin bad++; $display("FAIL single_rd_same_edge got=%0d want=1000", rd_data); end
    cyc();                       // edge k+3
    total++; if (rd_data !== 24'd981) begin bad++; $display("FAIL single_rd_after got=%0d want=981", rd_data); end
  endtask

  task automatic test_forwarding;
    upd_valid = 1'b1; upd_addr = 4'd5; upd_dt = 8'd20; rd_addr = 4'd5;
    cyc();                       // edge k
    cyc();                       // edge k+1
    upd_valid = 1'b0; upd_dt = 8'd0;
    total++; if ((wr_valid !== 1'b1) || (wr_data !== 24'd819)) begin bad++; $display("FAIL fwd_first got=%0b/%0d want=1/819", wr_valid, wr_data); end
    cyc();                       // edge k+2
    total++; if ((wr_valid !== 1'b1) || (wr_data !== 24'd638)) begin bad++; $display("FAIL fwd_second got=%0b/%0d want=1/638", wr_valid, wr_data); end
    total++; if (wr_addr !== 4'd5) begin bad++; $display("FAIL fwd_wr_addr got=%0d want=5", wr_addr); end
    cyc(); cyc();
    total++; if (rd_data !== 24'd638) begin bad++; $display("FAIL fwd_rd got=%0d want=638", rd_data); end
  endtask

  task automatic test_saturation;
    int exp_w [6];
`ifdef STDP_UPD_STATS_EN
    logic [15:0] u0;
    logic [15:0] s0;
    u0 = upd_cnt; s0 = sat_cnt;
`endif
    exp_w = '{819, 638, 457, 276, 95, 0};
    upd_valid = 1'b1; upd_addr = 4'd0; upd_dt = 8'd20; rd_addr = 4'd0;
    cyc();
    for (int i = 0; i < 6; i++) begin
      cyc();
      total++;
      if ((wr_valid !== 1'b1) || (wr_data !== W'(exp_w[i]))) begin
        bad++; $display("FAIL sat_step[%0d] got=%0b/%0d want=1/%0d", i, wr_valid, wr_data, exp_w[i]);
      end
      if (i == 4) begin upd_valid = 1'b0; upd_dt = 8'd0; end
    end
    cyc(); cyc();
    total++; if (rd_data !== 24'd0) begin bad++; $display("FAIL sat_rd got=%0d want=0", rd_data); end
`ifdef STDP_UPD_STATS_EN
    total++; if ((upd_cnt - u0) !== 16'd6) begin bad++; $display("FAIL sat_upd_cnt got=%0d want=6", upd_cnt - u0); end
    total++; if ((sat_cnt - s0) !== 16'd1) begin bad++; $display("FAIL sat_sat_cnt got=%0d want=1", sat_cnt - s0); end
`endif
  endtask

  task automatic test_zero_delta;
    logic seen;
    seen = 1'b0;
    upd_valid = 1'b1; upd_addr = 4'd7; upd_dt = 8'd0;
    cyc();
    upd_dt = 8'd25;
    cyc();
    upd_valid = 1'b0; upd_dt = 8'd0;
    for (int i = 0; i < 4; i++) begin
      if (wr_valid !== 1'b0) seen = 1'b1;
      cyc();
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL zero_wr_valid got=%0b want=0", seen); end
    rd_addr = 4'd7;
    cyc();
    total++; if (rd_data !== 24'd1000) begin bad++; $display("FAIL zero_rd got=%0d want=1000", rd_data); end
  endtask

  task automatic test_clr_midflight;
    int   n;
    logic seen;
    seen = 1'b0;
    upd_valid = 1'b1; upd_addr = 4'd2; upd_dt = 8'd2;
    cyc();                       // edge k
    upd_valid = 1'b0; clr = 1'b1;
    cyc();                       // edge k+1
    clr = 1'b0;
    total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL clr_wr_valid got=%0b want=0", wr_valid); end
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL clr_upd_ready got=%0b want=0", upd_ready); end
    upd_valid = 1'b1; upd_addr = 4'd2; upd_dt = 8'd2;
    n = 0;
    while ((upd_ready !== 1'b1) && (n < 40)) begin
      cyc(); n++;
      if (wr_valid !== 1'b0) seen = 1'b1;
    end
    upd_valid = 1'b0; upd_dt = 8'd0;
    total++; if (n != 16) begin bad++; $display("FAIL clr_sweep_cycles got=%0d want=16", n); end
`ifdef STDP_UPD_STATS_EN
    total++; if ((upd_cnt !== 16'd0) || (sat_cnt !== 16'd0)) begin bad++; $display("FAIL clr_stats got=%0d/%0d want=0/0", upd_cnt, sat_cnt); end
`endif
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (wr_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL clr_ignored_upd got=%0b want=0", seen); end
    rd_addr = 4'd2;
    cyc();
    total++; if (rd_data !== 24'd1000) begin bad++; $display("FAIL clr_rd2 got=%0d want=1000", rd_data); end
    rd_addr = 4'd0;
    cyc();
    total++; if (rd_data !== 24'd1000) begin bad++; $display("FAIL clr_rd0 got=%0d want=1000", rd_data); end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_single();
    test_forwarding();
    test_saturation();
    test_zero_delta();
    test_clr_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
